// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and constants for the multiply/divide scheduler
//
// Purpose: op encodings, default latencies and FSM state type shared by
// md_calc and md_sched.
// Ports: none (package).
package md_pkg;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // mult/multu/div/divu occupy the encodings with op[2] clear.
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational 32x32 multiply and divide
//
// Purpose: computes the {hi,lo} result of mult/multu/div/divu in one pass.
// Ports:
//   op       in  3   operation code (md_pkg encodings)
//   a, b     in  32  operands (rs, rt)
//   result   out 64  {hi,lo}: product, or {remainder,quotient}
//   div_zero out 1   div/divu with b == 0
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  always_comb begin
    // Sign-extending to 64 bits makes the truncated unsigned product equal
    // the signed product.
    prod_u = {32'd0, a} * {32'd0, b};
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // Signed divide on magnitudes, then restore signs: quotient truncates
    // toward zero, remainder follows the dividend.
    neg_a   = (op == MD_DIV) & a[31];
    neg_b   = (op == MD_DIV) & b[31];
    mag_a   = neg_a ? (~a + 32'd1) : a;
    mag_b   = neg_b ? (~b + 32'd1) : b;
    // Substitute divisor avoids an undefined divide; result is discarded.
    divisor = (b == 32'd0) ? 32'd1 : mag_b;
    quo     = mag_a / divisor;
    rem     = mag_a % divisor;
    quo_s   = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
    rem_s   = neg_a ? (~rem + 32'd1) : rem;

    case (op)
      MD_MULT:          result = prod_s;
      MD_MULTU:         result = prod_u;
      MD_DIV, MD_DIVU:  result = {rem_s, quo_s};
      default:          result = 64'd0;
    endcase

    div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);
  end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler owning HI/LO
//
// Purpose: accepts MD ops from E, holds the unit busy for a fixed latency,
// commits results to HI/LO and requests stalls for HI/LO users in D.
// Ports:
//   clk, reset_n   in   clock, asynchronous active-low reset
//   start, op      in   E-stage MD op request and its code
//   a, b           in   forwarded rs / rt values
//   d_md_use       in   D-stage instruction touches the MD unit
//   busy           out  operation in flight (registered)
//   stall          out  stall request (combinational)
//   hi, lo         out  architectural HI / LO
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] calc_result;
  logic        calc_div_zero;

  md_calc u_calc (
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (calc_result),
    .div_zero (calc_div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (md_is_arith(op)) begin
            state_d = BUSY;
            cnt_d   = op[1] ? DIV_CNT : MULT_CNT;
            // Divide by zero commits the current HI/LO, which cannot change
            // while busy, so completion leaves them untouched.
            if (calc_div_zero) begin
              pend_hi_d = hi_q;
              pend_lo_d = lo_q;
            end else begin
              pend_hi_d = calc_result[63:32];
              pend_lo_d = calc_result[31:0];
            end
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      BUSY: begin
        // Any start arriving here is dropped.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q == BUSY);
  assign stall = d_md_use & (busy | (start & md_is_arith(op)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - self-checking bench for md_sched
module tb_md_sched;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  md_sched dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles plus the architectural registers.
  int          m_rem = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;

  function automatic logic [63:0] md_ref(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] cur);
    int    sx;
    int    sy;
    int    q;
    int    r;
    longint px;
    longint py;
    logic [63:0] res;
    sx = x;
    sy = y;
    res = cur;
    case (o)
      3'd0: begin
        px = longint'(sx);
        py = longint'(sy);
        res = px * py;
      end
      3'd1: res = {32'd0, x} * {32'd0, y};
      3'd2: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        res = {32'(r), 32'(q)};
      end
      3'd3: if (y != 0) res = {x % y, x / y};
      default: res = cur;
    endcase
    return res;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem  <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_pend <= 64'd0;
    end else if (m_rem > 0) begin
      if (m_rem == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
      m_rem <= m_rem - 1;
    end else if (start) begin
      if (op <= 3'd3) begin
        m_rem  <= (op >= 3'd2) ? 10 : 5;
        m_pend <= md_ref(op, a, b, {m_hi, m_lo});
      end else if (op == 3'd4) begin
        m_hi <= a;
      end else if (op == 3'd5) begin
        m_lo <= a;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
    check("stall", {31'd0, stall},
          {31'd0, d_md_use & ((m_rem > 0) | (start & (op <= 3'd3)))});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
  endtask

  task automatic count_busy(output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else n++;
    end
    @(posedge clk);
    #1;
  endtask

  int n;
  int s0;

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    a        = 32'd0;
    b        = 32'd0;
    d_md_use = 1'b0;
    #7;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    #5 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // signed mult -3 * 5
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    count_busy(n);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    // divu 7 / 2
    issue(3'd3, 32'd7, 32'd2);
    count_busy(n);
    check("divu_busy_cycles", n, 32'd10);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // div -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // stall window with d_md_use held from the start cycle
    start    = 1'b1;
    op       = 3'd0;
    a        = 32'd3;
    b        = 32'd4;
    d_md_use = 1'b1;
    @(negedge clk);
    s0 = stall ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check("stall_cycles", s0 + n, 32'd6);
    @(posedge clk);
    #1;
    d_md_use = 1'b0;
    check("stall_mult_lo", lo, 32'd12);

    // mthi/mtlo preload, then divide by zero
    issue(3'd4, 32'h11, 32'd0);
    issue(3'd5, 32'h22, 32'd0);
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    check("mtx_not_busy", {31'd0, busy}, 32'd0);
    issue(3'd2, 32'd5, 32'd0);
    count_busy(n);
    check("div0_busy_cycles", n, 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // reserved op changes nothing
    issue(3'd7, 32'h55, 32'h66);
    issue(3'd6, 32'h77, 32'h88);
    check("rsv_busy", {31'd0, busy}, 32'd0);
    check("rsv_hi", hi, 32'h11);
    check("rsv_lo", lo, 32'h22);

    // ops while busy are ignored
    d_md_use = 1'b1;
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd4, 32'hAAAA, 32'd0);
    issue(3'd0, 32'd3, 32'd3);
    count_busy(n);
    d_md_use = 1'b0;
    check("ign_busy_rest", n, 32'd8);
    check("ign_hi", hi, 32'd2);
    check("ign_lo", lo, 32'd14);

    // multu max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'd1);

    // reset in the middle of a div
    issue(3'd2, 32'd100, 32'd3);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3'd0, 32'd6, 32'd7);
    count_busy(n);
    check("post_rst_busy_cycles", n, 32'd5);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
